// File: rtl/resize_axis_packer_pkg.sv
// Shared types and constants for the resizer output packer.
package resize_pkg;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned DIM_W = 16;

    // FIFO word is {sof, eol, data}; offsets are counted above the pixel field.
    localparam int unsigned EOL_OFS = 0;
    localparam int unsigned SOF_OFS = 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;
endpackage

// File: rtl/resize_axis_packer_if.sv
// AXI4-Stream video bus as seen from the packer (master) and the sink (slave).
interface resize_axis_packer_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/resize_axis_packer_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             out_valid;
    logic             wr_ok, load;

    // Occupancy includes the word parked in the output register.
    assign count = mem_cnt + (AW + 1)'(out_valid);
    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = !out_valid;
    assign wr_ok = wr_en && !full;
    assign load  = (mem_cnt != '0) && (!out_valid || rd_en);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            mem_cnt <= mem_cnt + (AW + 1)'(wr_ok) - (AW + 1)'(load);
            if (load) begin
                dout      <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
            end else if (rd_en) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/resize_axis_packer.sv
// Frames the resizer's unframed pixel stream as AXI4-Stream video (tuser=SOF, tlast=EOL)
// behind an elastic FIFO, with sticky overflow/config-error flags and a frame-done pulse.
module resize_axis_packer
    import resize_pkg::*;
#(
    parameter int unsigned DATA_W      = PIX_W,
    parameter int unsigned FIFO_DEPTH  = 1024,
    parameter int unsigned AFULL_LEVEL = 1008
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DIM_W-1:0]             out_width,
    input  logic [DIM_W-1:0]             out_height,
    input  logic                         valid_i,
    input  logic [DATA_W-1:0]            data_i,
    resize_axis_packer_if.master         m_axis,
    output logic                         fifo_afull,
    output logic                         overflow,
    output logic                         cfg_err,
    output logic                         frame_done
);
    localparam int unsigned WORD_W = DATA_W + 2;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    logic [DIM_W-1:0]   x, y, w_m1, h_m1;
    logic               dim_ok, first_eol, first_last, cur_eol, cur_last;
    logic               accept, wr_eol, wr_en, full, empty;
    logic [WORD_W-1:0]  din, dout;
    logic [CNT_W-1:0]   count;

    always_comb begin
        dim_ok     = (out_width != '0) && (out_height != '0);
        first_eol  = out_width == DIM_W'(1);
        first_last = first_eol && (out_height == DIM_W'(1));
        cur_eol    = x == w_m1;
        cur_last   = cur_eol && (y == h_m1);
        accept     = valid_i && ((state == ACTIVE) || dim_ok);
        wr_eol     = (state == IDLE) ? first_eol : cur_eol;
        wr_en      = accept && !full;
        din                     = '0;
        din[DATA_W-1:0]         = data_i;
        din[DATA_W + SOF_OFS]   = state == IDLE;
        din[DATA_W + EOL_OFS]   = wr_eol;
    end

    // Counters advance on dropped (full) pixels too, keeping later frames aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            w_m1       <= '0;
            h_m1       <= '0;
            overflow   <= 1'b0;
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept && full) overflow <= 1'b1;
            case (state)
                IDLE: if (valid_i) begin
                    if (!dim_ok) begin
                        cfg_err <= 1'b1;
                    end else begin
                        w_m1 <= out_width - DIM_W'(1);
                        h_m1 <= out_height - DIM_W'(1);
                        if (first_last) begin
                            frame_done <= 1'b1;
                        end else begin
                            state <= ACTIVE;
                            x     <= first_eol ? '0 : DIM_W'(1);
                            y     <= first_eol ? DIM_W'(1) : '0;
                        end
                    end
                end
                ACTIVE: if (valid_i) begin
                    if (cur_eol) begin
                        x <= '0;
                        if (cur_last) begin
                            y          <= '0;
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            y <= y + DIM_W'(1);
                        end
                    end else begin
                        x <= x + DIM_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .din     (din),
        .full    (full),
        .rd_en   (m_axis.tready),
        .dout    (dout),
        .empty   (empty),
        .count   (count)
    );

    assign fifo_afull    = count >= CNT_W'(AFULL_LEVEL);
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = dout[DATA_W-1:0];
    assign m_axis.tuser  = dout[DATA_W + SOF_OFS];
    assign m_axis.tlast  = dout[DATA_W + EOL_OFS];
endmodule

// File: tb/tb_resize_axis_packer.sv
// Scoreboard bench for resize_axis_packer: drives framed pixel bursts, checks every AXI transfer.
module tb_resize_axis_packer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] out_width = '0;
    logic [15:0] out_height = '0;
    logic        valid_i = 1'b0;
    logic [23:0] data_i = '0;
    logic        fifo_afull, overflow, cfg_err, frame_done;

    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          fd_base;
    bit          stalled = 1'b0;
    logic [25:0] held;
    logic [25:0] q[$];

    resize_axis_packer_if #(.DATA_W(24)) m_axis ();

    resize_axis_packer #(
        .DATA_W      (24),
        .FIFO_DEPTH  (DEPTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .out_width  (out_width),
        .out_height (out_height),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .m_axis     (m_axis),
        .fifo_afull (fifo_afull),
        .overflow   (overflow),
        .cfg_err    (cfg_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one pixel for one cycle; the bench's own occupancy model decides drops.
    task automatic send_pix(input logic [23:0] d, input bit sof, input bit eol, input bit keep);
        check_eq("afull", 32'(fifo_afull), 32'(q.size() >= AFULL));
        valid_i = 1'b1;
        data_i  = d;
        if (keep && q.size() < DEPTH) q.push_back({sof, eol, d});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int w, input int h, input int chg_at, input logic [15:0] chg_w);
        for (int p = 0; p < w * h; p++) begin
            if (p == chg_at) out_width = chg_w;
            send_pix(24'($urandom), p == 0, (p % w) == w - 1, 1'b1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1);
        idle(2);
        check_eq("drain", 32'(q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (m_axis.tvalid && m_axis.tready) begin
                if (q.size() == 0) check_eq("out_q", 32'(q.size()), 1);
                else check_eq("pix", {6'd0, m_axis.tuser, m_axis.tlast, m_axis.tdata}, {6'd0, q.pop_front()});
            end
            if (m_axis.tvalid && !m_axis.tready) begin
                if (stalled) check_eq("hold", {6'd0, m_axis.tuser, m_axis.tlast, m_axis.tdata}, {6'd0, held});
                held    = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        m_axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 32'(m_axis.tvalid), 0);
        check_eq("rst_flags", {28'd0, fifo_afull, overflow, cfg_err, frame_done}, 0);
        check_eq("rst_side", {30'd0, m_axis.tuser, m_axis.tlast}, 0);
        reset_n = 1'b1;
        idle(1);

        // 4x2 frame at full rate: latency, tlast placement and frame_done timing.
        out_width  = 16'd4;
        out_height = 16'd2;
        fd_base    = fd_cnt;
        for (int p = 0; p < 8; p++) begin
            send_pix(24'($urandom), p == 0, (p % 4) == 3, 1'b1);
            if (p == 0) check_eq("lat0", 32'(m_axis.tvalid), 0);
            if (p == 1) check_eq("lat1", 32'(m_axis.tvalid), 1);
            if (p == 6) check_eq("fd_early", 32'(frame_done), 0);
            if (p == 7) check_eq("fd_pulse", 32'(frame_done), 1);
        end
        idle(1);
        check_eq("fd_after", 32'(frame_done), 0);
        drain();
        check_eq("fd_cnt1", 32'(fd_cnt - fd_base), 1);

        // 4x2 frame with a 6-cycle sink stall mid-frame.
        for (int p = 0; p < 8; p++) begin
            if (p == 3) m_axis.tready = 1'b0;
            if (p >= 4) check_eq("stall_valid", 32'(m_axis.tvalid), 1);
            send_pix(24'($urandom), p == 0, (p % 4) == 3, 1'b1);
        end
        check_eq("stall_valid", 32'(m_axis.tvalid), 1);
        idle(1);
        m_axis.tready = 1'b1;
        drain();
        check_eq("no_ovf", 32'(overflow), 0);

        // 20x1 frame into a stalled 16-deep FIFO: afull at 12, last four dropped.
        m_axis.tready = 1'b0;
        out_width  = 16'd20;
        out_height = 16'd1;
        send_frame(20, 1, -1, 16'd0);
        idle(1);
        check_eq("ovf", 32'(overflow), 1);
        check_eq("afull_full", 32'(fifo_afull), 1);
        check_eq("kept", 32'(q.size()), DEPTH);
        m_axis.tready = 1'b1;
        idle(4);
        out_width = 16'd4;
        send_frame(4, 1, -1, 16'd0);
        drain();

        // Three back-to-back 1x1 frames.
        out_width  = 16'd1;
        out_height = 16'd1;
        fd_base    = fd_cnt;
        send_frame(1, 1, -1, 16'd0);
        send_frame(1, 1, -1, 16'd0);
        send_frame(1, 1, -1, 16'd0);
        drain();
        check_eq("fd_cnt3", 32'(fd_cnt - fd_base), 3);

        // Width change mid-frame only applies to the next frame.
        out_width  = 16'd4;
        out_height = 16'd2;
        send_frame(4, 2, 2, 16'd2);
        send_frame(2, 2, -1, 16'd0);
        drain();

        // Zero height: pixel dropped, cfg_err latched.
        out_height = 16'd0;
        send_pix(24'($urandom), 1'b1, 1'b0, 1'b0);
        idle(4);
        check_eq("cfg_err", 32'(cfg_err), 1);
        check_eq("zero_tvalid", 32'(m_axis.tvalid), 0);
        out_height = 16'd2;

        // Asynchronous reset mid-frame with data parked on the output.
        m_axis.tready = 1'b0;
        send_frame(4, 2, 3, 16'd4);
        idle(2);
        check_eq("pre_rst_valid", 32'(m_axis.tvalid), 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_drop_valid", 32'(m_axis.tvalid), 0);
        check_eq("rst_clr_flags", {29'd0, overflow, cfg_err, fifo_afull}, 0);
        q.delete();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        m_axis.tready = 1'b1;
        send_frame(4, 2, -1, 16'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/resize_axis_packer.md
Name: resize_axis_packer

Overview:
- Sits directly downstream of the bilinear resizer.
- Consumes its unframed pixel stream (valid/24-bit RGB, no backpressure) and frames it as AXI4-Stream video: tuser marks start of frame, tlast marks end of line.
- Buffers pixels in an internal FIFO so a stalling sink (VDMA) can be absorbed, and reports overflow and frame completion to the control logic.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- FIFO_DEPTH, 1024, FIFO entries; power of two, minimum 4.
- AFULL_LEVEL, 1008, occupancy at or above which fifo_afull asserts.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- out_width  in  16  pixels per output line; sampled at frame start.
- out_height  in  16  lines per output frame; sampled at frame start.
- valid_i  in  1  input pixel strobe from the resizer.
- data_i  in  DATA_W  input pixel.
- m_axis_tdata  out  DATA_W  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- fifo_afull  out  1  FIFO occupancy >= AFULL_LEVEL.
- overflow  out  1  sticky; a pixel was dropped.
- cfg_err  out  1  sticky; a frame started with zero width or height.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written into the FIFO.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0; latched dimensions 0.
- Write-side FSM, two states:
  - IDLE:
    - On valid_i, latch out_width/out_height into w_l/h_l.
    - If either dimension is 0: drop the pixel, set cfg_err, stay IDLE.
    - Otherwise write the pixel with sof=1, set x=1, y=0, go ACTIVE.
    - A 1x1 frame writes sof=1 and eol=1, pulses frame_done, and stays IDLE.
  - ACTIVE: each valid_i writes {sof=0, eol=(x==w_l-1), data}.
    - x wraps to 0 on eol, and y increments.
    - When eol and y==h_l-1: pulse frame_done in the following cycle, go IDLE.
- Port changes to out_width/out_height while ACTIVE are ignored until the next IDLE->ACTIVE transition.
- FIFO word layout: {sof, eol, data}, width DATA_W+2.
  - Write enable = accepted pixel AND not full.
  - Full-cycle write: the pixel is discarded and overflow is set.
  - Counters still advance on a full-cycle write, so framing stays aligned for subsequent frames.
  - Write and read in the same cycle while full is treated as full: the pixel is dropped.
- Read side: first-word-fall-through with registered outputs.
  - m_axis_tvalid rises 2 cycles after the write cycle of a pixel into an empty FIFO.
  - tdata/tuser/tlast are held stable while tvalid && !tready (AXI rule).
  - Transfer occurs on tvalid && tready.
  - Sustained 1 pixel/cycle when tready is high.
- fifo_afull is combinational from the occupancy count and is intended to gate upstream wr_ready.
- overflow and cfg_err clear only on reset.
- Asynchronous reset mid-frame:
  - Everything returns to reset values immediately.
  - FIFO contents are discarded.
  - The next valid_i after release is treated as start of frame.
- Counters are 16 bit; the compare uses w_l-1 and h_l-1 computed at latch time, so no wrap is possible for legal dimensions.

Decomposition:
- Package resize_pkg:
  - PIX_W=24, DIM_W=16.
  - FIFO word field offsets SOF_BIT/EOL_BIT.
  - FSM state enum {IDLE, ACTIVE}.
- Sub-module sync_fifo_fwft:
  - Parameters DEPTH and WIDTH.
  - Ports wr_en/din/full, rd_en/dout/empty, count.
  - Registered FWFT output stage.
  - Reused by other stream stages.
- Top level holds the FSM, counters, sticky flags, and the AXI output mapping.

Test Plan:
- 4x2 frame, tready=1, 8 consecutive valid_i: 8 transfers; tuser on pixel 0 only; tlast on pixels 3 and 7; frame_done pulses once, one cycle after pixel 7 is written; first tvalid 2 cycles after the first valid_i.
- 4x2 frame, tready low for 6 cycles mid-frame: tvalid stays high with stable tdata/tuser/tlast; after release all 8 pixels arrive in order; overflow=0.
- FIFO_DEPTH=16, AFULL_LEVEL=12, tready=0, 20 pixels of a 20x1 frame: fifo_afull asserts at occupancy 12; pixels 17-20 are dropped; overflow=1.
  - Then release tready and send a 4x1 frame: 16 old pixels arrive, then the new frame with tuser on its first pixel.
- 1x1 frames, three back-to-back pixels: each output has tuser=1 and tlast=1; frame_done pulses 3 times.
- out_width changes from 4 to 2 mid-frame: the current frame keeps tlast every 4 pixels; the next frame uses 2.
- Zero and reset cases:
  - out_height=0 with pixel sent: no output, cfg_err=1.
  - reset_n pulsed low mid-frame: tvalid drops immediately and flags clear; the next pixel carries tuser=1.
